// File: rtl/imem_load_seq.sv
// Instruction-memory load sequencer: streams words into the CPU init port, then releases CPU reset.
// Define IMEM_LOAD_CHECKSUM_EN to require a trailing XOR checksum beat before release.
module imem_load_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [6:0]  len,
  input  logic [31:0] base_addr,
  input  logic        in_valid,
  input  logic [31:0] in_data,
  output logic        in_ready,
  output logic        cpu_rst,
  output logic        initialize,
  output logic [31:0] instruction_initialize_data,
  output logic [31:0] instruction_initialize_address,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [6:0]  words_loaded
);

`ifdef IMEM_LOAD_CHECKSUM_EN
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RELEASE, S_RUN, S_CHECK, S_ERROR} state_t;
  localparam state_t POST_LOAD = S_CHECK;
`else
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RELEASE, S_RUN} state_t;
  localparam state_t POST_LOAD = S_RELEASE;
`endif

  state_t      state;
  state_t      state_nxt;
  state_t      entry_state;
  logic        start_ok;
  logic        beat;
  logic [6:0]  remaining;
  logic [31:0] next_addr;
`ifdef IMEM_LOAD_CHECKSUM_EN
  logic [31:0] xor_acc;
`endif

  assign beat        = in_valid && in_ready;
  assign entry_state = (len == 7'd0) ? POST_LOAD : S_LOAD;

  always_comb begin
    start_ok  = 1'b0;
    state_nxt = state;
    case (state)
      S_IDLE, S_RUN: begin
        if (start) begin
          start_ok  = 1'b1;
          state_nxt = entry_state;
        end
      end
      S_LOAD:    if (beat && remaining == 7'd1) state_nxt = POST_LOAD;
      S_RELEASE: state_nxt = S_RUN;
`ifdef IMEM_LOAD_CHECKSUM_EN
      S_CHECK:   if (beat) state_nxt = (in_data == xor_acc) ? S_RELEASE : S_ERROR;
      S_ERROR: begin
        if (start) begin
          start_ok  = 1'b1;
          state_nxt = entry_state;
        end
      end
`endif
      default:   state_nxt = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state                          <= S_IDLE;
      cpu_rst                        <= 1'b1;
      initialize                     <= 1'b0;
      in_ready                       <= 1'b0;
      busy                           <= 1'b0;
      done                           <= 1'b0;
      words_loaded                   <= 7'd0;
      remaining                      <= 7'd0;
      next_addr                      <= 32'd0;
      instruction_initialize_data    <= 32'd0;
      instruction_initialize_address <= 32'd0;
`ifdef IMEM_LOAD_CHECKSUM_EN
      error                          <= 1'b0;
      xor_acc                        <= 32'd0;
`endif
    end else begin
      state      <= state_nxt;
      cpu_rst    <= (state_nxt != S_RUN);
      initialize <= (state_nxt == S_LOAD);
      done       <= (state_nxt == S_RUN) && (state != S_RUN);
`ifdef IMEM_LOAD_CHECKSUM_EN
      in_ready   <= (state_nxt == S_LOAD) || (state_nxt == S_CHECK);
      busy       <= (state_nxt == S_LOAD) || (state_nxt == S_RELEASE) || (state_nxt == S_CHECK);
      error      <= (state_nxt == S_ERROR);
`else
      in_ready   <= (state_nxt == S_LOAD);
      busy       <= (state_nxt == S_LOAD) || (state_nxt == S_RELEASE);
`endif
      if (start_ok) begin
        // The base address is presented with zero data before the first beat.
        next_addr                      <= base_addr & 32'hFFFF_FFFC;
        instruction_initialize_address <= base_addr & 32'hFFFF_FFFC;
        instruction_initialize_data    <= 32'd0;
        words_loaded                   <= 7'd0;
        remaining                      <= len;
`ifdef IMEM_LOAD_CHECKSUM_EN
        xor_acc                        <= 32'd0;
`endif
      end else if (beat && state == S_LOAD) begin
        instruction_initialize_data    <= in_data;
        instruction_initialize_address <= next_addr;
        next_addr                      <= next_addr + 32'd4;
        words_loaded                   <= words_loaded + 7'd1;
        remaining                      <= remaining - 7'd1;
`ifdef IMEM_LOAD_CHECKSUM_EN
        xor_acc                        <= xor_acc ^ in_data;
`endif
      end
    end
  end

`ifndef IMEM_LOAD_CHECKSUM_EN
  assign error = 1'b0;
`endif

endmodule

// File: tb/tb_imem_load_seq.sv
// Scoreboard bench for imem_load_seq: expected CPU writes and session completions are queued
// by the stimulus and consumed by an independent output monitor.
module tb_imem_load_seq;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [6:0]  len = 7'd0;
  logic [31:0] base_addr = 32'd0;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = 32'd0;
  logic        in_ready, cpu_rst, initialize, busy, done, error;
  logic [31:0] wr_data, wr_addr;
  logic [6:0]  words_loaded;

  imem_load_seq dut (
    .clk(clk), .rst(rst), .start(start), .len(len), .base_addr(base_addr),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .cpu_rst(cpu_rst), .initialize(initialize),
    .instruction_initialize_data(wr_data),
    .instruction_initialize_address(wr_addr),
    .busy(busy), .done(done), .error(error), .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [6:0]  cnt;
  } wr_t;

  wr_t exp_wr[$];
  int  exp_done[$];
  int  checks = 0;
  int  errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: a new CPU write is visible whenever words_loaded steps to a non-zero value.
  initial begin
    logic [6:0] prev_wl;
    wr_t        e;
    int         n;
    prev_wl = 7'd0;
    forever begin
      @(negedge clk);
      if (words_loaded != prev_wl && words_loaded != 7'd0) begin
        if (exp_wr.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_write: got count %0d expected no write", words_loaded);
        end else begin
          e = exp_wr.pop_front();
          chk("wr_addr", wr_addr, e.addr);
          chk("wr_data", wr_data, e.data);
          chk("wr_count", 32'(words_loaded), 32'(e.cnt));
        end
      end
      if (done === 1'b1) begin
        if (exp_done.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_done: got done=1 expected no completion");
        end else begin
          n = exp_done.pop_front();
          chk("done_count", 32'(words_loaded), 32'(n));
          chk("done_cpu_rst", 32'(cpu_rst), 32'd0);
        end
      end
      prev_wl = words_loaded;
    end
  end

  task automatic check_reset_state(input string tag);
    chk({tag, "_cpu_rst"}, 32'(cpu_rst), 32'd1);
    chk({tag, "_initialize"}, 32'(initialize), 32'd0);
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_error"}, 32'(error), 32'd0);
    chk({tag, "_words"}, 32'(words_loaded), 32'd0);
    chk({tag, "_data"}, wr_data, 32'd0);
    chk({tag, "_addr"}, wr_addr, 32'd0);
  endtask

  task automatic send_beat(input logic [31:0] d);
    bit ok;
    ok = 1'b0;
    @(negedge clk);
    start = 1'b0;
    in_valid = 1'b1;
    in_data = d;
    for (int t = 0; t < 20 && !ok; t++) begin
      if (t > 0) @(negedge clk);
      ok = in_ready;
      @(posedge clk);
    end
    #1 in_valid = 1'b0;
    if (!ok) chk("beat_timeout", 32'd0, 32'd1);
  endtask

  // Starts a session; in_valid is randomly raised alongside start and must be ignored.
  task automatic start_session(input logic [6:0] n, input logic [31:0] base);
    @(negedge clk);
    start = 1'b1;
    len = n;
    base_addr = base;
    in_valid = 1'($urandom_range(0, 1));
    in_data = $urandom;
    @(negedge clk);
    start = 1'b0;
    in_valid = 1'b0;
    chk("entry_cpu_rst", 32'(cpu_rst), 32'd1);
    chk("entry_words", 32'(words_loaded), 32'd0);
    chk("entry_initialize", 32'(initialize), (n != 0) ? 32'd1 : 32'd0);
    if (n != 0) begin
      chk("entry_in_ready", 32'(in_ready), 32'd1);
      chk("entry_busy", 32'(busy), 32'd1);
      chk("entry_addr", wr_addr, base & 32'hFFFF_FFFC);
      chk("entry_data", wr_data, 32'd0);
    end else begin
`ifdef IMEM_LOAD_CHECKSUM_EN
      chk("entry_check_in_ready", 32'(in_ready), 32'd1);
`else
      chk("entry_release_in_ready", 32'(in_ready), 32'd0);
      chk("entry_release_busy", 32'(busy), 32'd1);
`endif
    end
  endtask

  task automatic check_release();
    @(negedge clk);
    chk("rel_cpu_rst", 32'(cpu_rst), 32'd1);
    chk("rel_initialize", 32'(initialize), 32'd0);
    chk("rel_in_ready", 32'(in_ready), 32'd0);
    chk("rel_busy", 32'(busy), 32'd1);
    chk("rel_done", 32'(done), 32'd0);
  endtask

  task automatic check_run();
    @(negedge clk);
    chk("run_cpu_rst", 32'(cpu_rst), 32'd0);
    chk("run_done", 32'(done), 32'd1);
    chk("run_busy", 32'(busy), 32'd0);
    chk("run_error", 32'(error), 32'd0);
    @(negedge clk);
    chk("run_done_pulse", 32'(done), 32'd0);
    chk("run_cpu_rst_hold", 32'(cpu_rst), 32'd0);
  endtask

  // Full session: expected write i lands at aligned_base + 4*i, wrapping modulo 2^32.
  task automatic run_session(input logic [6:0] n, input logic [31:0] base, input int gap,
                             input bit seq_data, input bit poke_start);
    logic [31:0] b;
    logic [31:0] x;
    logic [31:0] d;
    logic [31:0] prev_d;
    b = base & 32'hFFFF_FFFC;
    x = 32'd0;
    prev_d = 32'd0;
    start_session(n, base);
    for (int i = 0; i < int'(n); i++) begin
      for (int g = 0; g < gap; g++) begin
        @(negedge clk);
        start = poke_start;
        len = 7'($urandom);
        chk("gap_in_ready", 32'(in_ready), 32'd1);
        chk("gap_initialize", 32'(initialize), 32'd1);
        chk("gap_addr_hold", wr_addr, b + 32'(4 * ((i > 0) ? i - 1 : 0)));
        chk("gap_data_hold", wr_data, prev_d);
      end
      d = seq_data ? 32'(i + 1) : $urandom;
      x ^= d;
      prev_d = d;
      exp_wr.push_back('{b + 32'(4 * i), d, 7'(i + 1)});
      send_beat(d);
    end
    exp_done.push_back(int'(n));
`ifdef IMEM_LOAD_CHECKSUM_EN
    send_beat(x);
    check_release();
`else
    if (n != 0) check_release();
`endif
    check_run();
  endtask

  initial begin
    logic [31:0] d;
    repeat (3) @(negedge clk);
    check_reset_state("por");
    rst = 1'b0;

    run_session(7'd3, 32'h0000_0000, 0, 1'b1, 1'b0);
    run_session(7'd3, 32'h0000_0000, 2, 1'b0, 1'b1);
    run_session(7'd2, 32'hFFFF_FFFC, 0, 1'b0, 1'b0);
    run_session(7'd0, 32'h1234_5678, 0, 1'b0, 1'b0);
    run_session(7'd2, 32'h0000_0103, 1, 1'b1, 1'b0);

    // Reset in the middle of a three-word load.
    start_session(7'd3, 32'hA5A5_0010);
    d = $urandom | 32'h1;
    exp_wr.push_back('{32'hA5A5_0010, d, 7'd1});
    send_beat(d);
    @(negedge clk);
    rst = 1'b1;
    start = 1'b1;
    in_valid = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    start = 1'b0;
    in_valid = 1'b0;
    check_reset_state("midrst");

`ifdef IMEM_LOAD_CHECKSUM_EN
    // Wrong checksum parks in ERROR with the CPU held in reset.
    start_session(7'd2, 32'h0000_0040);
    exp_wr.push_back('{32'h0000_0040, 32'd1, 7'd1});
    send_beat(32'd1);
    exp_wr.push_back('{32'h0000_0044, 32'd2, 7'd2});
    send_beat(32'd2);
    send_beat(32'd4);
    repeat (2) @(negedge clk);
    chk("err_error", 32'(error), 32'd1);
    chk("err_cpu_rst", 32'(cpu_rst), 32'd1);
    chk("err_in_ready", 32'(in_ready), 32'd0);
    chk("err_busy", 32'(busy), 32'd0);
`endif

    for (int s = 0; s < 8; s++)
      run_session(7'($urandom_range(1, 12)), $urandom, $urandom_range(0, 2), 1'b0,
                  1'($urandom_range(0, 1)));
    run_session(7'd127, $urandom, 0, 1'b0, 1'b0);

    repeat (3) @(negedge clk);
    chk("wr_queue_drained", 32'(exp_wr.size()), 32'd0);
    chk("done_queue_drained", 32'(exp_done.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule
